cache_fill_fsm: RTL

Parametrised miss-handling controller for the pipelined CPU's caches. One instance sits beside the I-cache and one beside the D-cache. On a miss it fetches a whole block from multicycle, pipelined main memory and streams each returned word into the cache data array, then writes the tag. While busy it holds the fetch or MEM stage stalled through the hazard unit.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cache_fill_fsm_fill_counter.sv | 35 +++
 rtl/cache_fill_fsm.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU cache controllers: the fill FSM state encoding
// and a constant-width helper.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and enable, flagging when it holds TERMINAL.
// Used for both the request and return sides of a block fill.
module fill_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count       = count_q;
  assign at_terminal = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined memory, streams
// each returned word into the data array, then writes the tag.
module cache_fill_fsm
  import cpu_pkg::*;
#(
  parameter int   ADDR_W          = 16,
  parameter int   DATA_W          = 16,
  parameter int   WORDS_PER_BLOCK = 8,
  parameter int   MEM_LAT         = 4,
  localparam int  IDX_W           = clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  cache_word_index,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_base
);

  localparam int CNT_W = IDX_W + 1;
  localparam int OFF   = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
      MEM_LAT < 1) begin : g_bad_params
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of 2 >= 2 and MEM_LAT >= 1");
  end

  fill_state_e       state_q, state_d;
  logic              fsm_busy_q, fsm_busy_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              issue_done, recv_last;
  logic              start_fill, recv_fire;

  assign start_fill = (state_q == IDLE) && miss_detected;
  assign recv_fire  = (state_q == FILL) && memory_data_valid;

  fill_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_fill),
    .en          (mem_req),
    .count       (issue_cnt),
    .at_terminal (issue_done)
  );

  fill_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_fill),
    .en          (recv_fire),
    .count       (recv_cnt),
    .at_terminal (recv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fsm_busy_q  <= 1'b0;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      fsm_busy_q  <= fsm_busy_d;
      fill_base_q <= fill_base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_base_d = fill_base_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          fill_base_d = miss_address & ~OFF_MASK;
        end
      end
      FILL: begin
        if (recv_fire && recv_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fsm_busy_d = (state_d == FILL);
  end

  always_comb begin
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_index = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    if (state_q == FILL) begin
      if (!issue_done) begin
        mem_req        = 1'b1;
        memory_address = fill_base_q + ADDR_W'({issue_cnt, 1'b0});
      end
      // recv_cnt's top bit only sets once the whole block has arrived.
      if (memory_data_valid && !recv_cnt[IDX_W]) begin
        write_data_array = 1'b1;
        cache_word_index = recv_cnt[IDX_W-1:0];
        fill_data        = memory_data;
        write_tag_array  = recv_last;
      end
    end
  end

  assign fsm_busy  = fsm_busy_q;
  assign fill_base = fill_base_q;

endmodule
